// File: rtl/sized_mem_pkg.sv
// rtl/sized_mem_pkg.sv - size encodings, FSM state type and byte-lane mask helper
package sized_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } mem_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr;
            SZ_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed lane(s) of a word and sign/zero-extends
module mem_load_align
    import sized_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {addr_i, 3'b000};
        case (size_i)
            SZ_BYTE: result_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/sized_data_memory.sv
// rtl/sized_data_memory.sv - byte/half/word data memory with zero-fill sweep and one-deep response
module sized_data_memory
    import sized_mem_pkg::*;
#(
    parameter int DEPTH         = 2048,
    parameter int INIT_ON_RESET = 1,
    parameter int TRACE         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [31:0]      mem_q [DEPTH];
    mem_state_e       state_q, state_d;
    logic [AW-1:0]    init_idx_q, init_idx_d;
    logic             init_done_q, init_done_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept;
    logic [AW-1:0]    idx;
    logic             req_err;
    logic [31:0]      rd_word;
    logic [3:0]       lanes;
    logic [31:0]      bit_mask;
    logic [31:0]      wdata_rep;
    logic [31:0]      merged;
    logic [31:0]      load_data;
    logic             store_commit;

    assign req_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready));
    assign accept    = req_valid && req_ready;

    // Any address bit above the index range makes the request out of range.
    assign idx     = req_addr[AW+1:2];
    assign req_err = (|req_addr[31:AW+2])
                   || (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && (|req_addr[1:0]));

    assign rd_word  = mem_q[idx];
    assign lanes    = lane_mask(req_size, req_addr[1:0]);
    assign bit_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};

    always_comb begin
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    assign merged       = (rd_word & ~bit_mask) | (wdata_rep & bit_mask);
    assign store_commit = accept && req_we && !req_err;

    mem_load_align u_align (
        .word_i     (rd_word),
        .addr_i     (req_addr[1:0]),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .result_o   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (state_q == ST_INIT) begin
            if (init_idx_q == LAST_IDX) begin
                state_d     = ST_IDLE;
                init_idx_d  = '0;
                init_done_d = 1'b1;
            end else begin
                init_idx_d = init_idx_q + 1'b1;
            end
        end
        if (accept) begin
            state_d     = ST_RESP;
            rsp_err_d   = req_err;
            rsp_rdata_d = (req_err || req_we) ? 32'h0 : load_data;
        end else if (state_q == ST_RESP && rsp_ready) begin
            state_d     = ST_IDLE;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage has no reset; the sweep provides the zero state.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[init_idx_q] <= 32'h0;
        end else if (store_commit) begin
            mem_q[idx] <= merged;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q || (INIT_ON_RESET == 0 && !reset);

`ifndef SYNTHESIS
    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!reset && store_commit) begin
                $display("@%h: *%h <= %h", req_pc, req_addr, merged);
            end
        end
    end
`endif

endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning the number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter INIT_ON_RESET, default 1, meaning zero-fill of all words after reset (0 = skip the fill).
REQ-003 SHALL have parameter TRACE, default 1, meaning simulation-only write trace enable.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_addr  input  32  byte address, little-endian.
REQ-012 req_wdata  input  32  store data; the low byte, half or word is used.
REQ-013 req_pc  input  32  program counter of the request, for trace only.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-016 rsp_rdata  output  32  extended load data; 0 for stores and for errors.
REQ-017 rsp_err  output  1  request was misaligned, out of range or had illegal size.
REQ-018 init_done  output  1  zero-fill complete.

Function
REQ-019 FSM states SHALL be INIT (sweep), IDLE (no response pending) and RESP (response held).
- Reset enters INIT if INIT_ON_RESET = 1, else IDLE.
REQ-020 INIT SHALL write 0 to word index 0..DEPTH-1, one word per clock (DEPTH cycles).
- After the sweep: state IDLE, init_done = 1.
- req_ready = 0 throughout INIT.
REQ-021 req_ready SHALL be 1 in IDLE, and in RESP only while rsp_ready = 1.
- A response consumed and a new request accepted in the same cycle keeps the FSM in RESP with the new response.
REQ-022 An accepted request SHALL produce exactly one response, rsp_valid high the cycle after acceptance (latency 1).
- The response SHALL stay stable until consumed.
REQ-023 Word index SHALL be req_addr[31:2]; an index >= DEPTH is out of range.
REQ-024 Error conditions SHALL be: half with addr[0] = 1, word with addr[1:0] != 0, size 11, or out of range.
- Memory is not modified; rsp_err = 1; rsp_rdata = 0.
REQ-025 Stores SHALL write only the addressed byte lanes (byte lane = addr[1:0], half lanes = addr[1]*2 and +1) and leave the other lanes unchanged.
REQ-026 Loads SHALL select the addressed lane(s), shift them to bit 0, then sign- or zero-extend per req_unsigned.
- Word loads ignore req_unsigned.
REQ-027 A load accepted the cycle after a store to the same word SHALL return the post-store contents.
REQ-028 When TRACE = 1, each committed store SHALL print "@<pc>: *<addr> <= <merged word>" in hex.
- Simulation only; no trace for errored stores.

Reset
REQ-029 Reset asserted SHALL immediately force rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0 and init_done = 0.
- With INIT_ON_RESET = 0, init_done = 1 once reset deasserts.
REQ-030 Reset mid-sweep or mid-response SHALL discard the pending response and restart the sweep from index 0.
- Memory contents are not otherwise guaranteed until init_done.

Structure
REQ-031 Package sized_mem_pkg SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the FSM state type and the lane-mask helper.
REQ-032 Load alignment/extension SHALL be a combinational sub-module mem_load_align (inputs: word, addr[1:0], size, unsigned; output: 32-bit result).

Verification
REQ-033 Reset with DEPTH = 16: req_ready low for exactly 16 cycles, then init_done = 1; a load of word at 0x3C returns 0x00000000.
REQ-034 Store word 0x11223344 @0x8, store byte 0xAA @0x9, then load word @0x8 -> 0x1122AA44.
- Load byte signed @0x9 -> 0xFFFFFFAA; byte unsigned @0x9 -> 0x000000AA.
REQ-035 Store half 0x8001 @0x6, then load half signed @0x6 -> 0xFFFF8001.
- Then load half @0x5 -> rsp_err = 1, rdata 0, word 1 unchanged.
REQ-036 rsp_ready held low 3 cycles: rsp_valid/rsp_rdata stable, req_ready = 0.
- Then rsp_ready high with a new request the same cycle: back-to-back responses with no bubble.
REQ-037 Store to word index DEPTH (addr = 4*DEPTH) -> rsp_err = 1, no trace line, all memory unchanged.
REQ-038 Reset asserted during RESP and again mid-sweep: rsp_valid drops the same cycle; the sweep restarts at 0 and takes a full DEPTH cycles.
